// File: rtl/score_pkg.sv
// score_pkg
// Shared types and constants for the Crazy-Snake score keeper.
//   state_t     : add/commit FSM states
//   bcd_t       : one BCD digit (0..9), 4'hF reserved as a blank digit
//   score_t     : four BCD digits packed, index 0 = ones
//   MAX_SCORE   : saturation value 9999
//   BLANK_DIGIT : digit code the seven-segment decoder shows as dark
package score_pkg;

  typedef enum logic [1:0] {IDLE, ADD, CMP, ACK} state_t;

  typedef logic [3:0] bcd_t;
  typedef bcd_t [3:0] score_t;

  localparam bcd_t   BLANK_DIGIT = 4'hF;
  localparam score_t MAX_SCORE   = {4'd9, 4'd9, 4'd9, 4'd9};

  // Every field holds 0..9, so an unsigned compare of the packed
  // vector is the same as a digit-by-digit BCD magnitude compare.
  function automatic logic score_gt(input score_t a, input score_t b);
    return a > b;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add
// Combinational single-digit BCD adder with carry.
//   a, b : BCD digits (0..9)
//   cin  : carry in
//   sum  : BCD result digit
//   cout : carry out (set when a+b+cin >= 10)
module bcd_digit_add
  import score_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] raw;
  logic [4:0] adj;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    adj  = raw - 5'd10;
    cout = (raw >= 5'd10);
    sum  = cout ? adj[3:0] : raw[3:0];
  end

endmodule

// File: rtl/score_display_scheduler.sv
// score_display_scheduler
// Keeps the 4-digit BCD score and high score, applies point adds one
// digit per cycle, and chooses what the seven-segment display shows.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   add_req, add_val   : add request level and points (values >9 clamp to 9)
//   add_ack            : one-cycle pulse when the add has been committed
//   clear_req          : pulse, zeroes the score (high score kept)
//   game_over          : selects score/high-score paging
//   digit0..digit3     : registered display digits, digit0 = ones, F = blank
//   page               : 0 = score page, 1 = high-score page
//   busy               : high while an add is in progress
// All outputs are registered, so add_ack/busy/digits follow the internal
// FSM state by one cycle.
module score_display_scheduler
  import score_pkg::*;
#(
  parameter int PAGE_CYCLES  = 50_000_000,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       add_req,
  input  logic [3:0] add_val,
  output logic       add_ack,
  input  logic       clear_req,
  input  logic       game_over,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       page,
  output logic       busy
);

  localparam int PW = (PAGE_CYCLES  > 1) ? $clog2(PAGE_CYCLES)  : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [PW-1:0] PAGE_LAST  = PW'(PAGE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  state_t     state;
  score_t     score, work, high;
  bcd_t       addend;
  logic [1:0] idx;
  logic       carry, clear_pend;

  logic [PW-1:0] page_cnt, page_cnt_nxt;
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          blink_on, blink_on_nxt, page_nxt;
  score_t        disp, disp_nxt;

  bcd_t add_b, add_sum;
  logic add_cout;

  // The addend only enters the ones digit; higher digits just ripple carry.
  assign add_b = (idx == 2'd0) ? addend : 4'd0;

  bcd_digit_add u_add (
    .a    (work[idx]),
    .b    (add_b),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      score      <= '0;
      work       <= '0;
      high       <= '0;
      addend     <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      clear_pend <= 1'b0;
      add_ack    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      add_ack <= (state == ACK);
      busy    <= (state != IDLE);
      // A clear arriving mid-add waits until the add has committed.
      if (state != IDLE && clear_req) clear_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (clear_req || clear_pend) begin
            score      <= '0;
            work       <= '0;
            clear_pend <= 1'b0;
          end else if (add_req) begin
            addend <= (add_val > 4'd9) ? 4'd9 : add_val;
            work   <= score;
            idx    <= 2'd0;
            carry  <= 1'b0;
            state  <= ADD;
          end
        end
        ADD: begin
          work[idx] <= add_sum;
          carry     <= add_cout;
          idx       <= idx + 2'd1;
          if (idx == 2'd3) begin
            if (add_cout) work <= MAX_SCORE;
            state <= CMP;
          end
        end
        CMP: begin
          score <= work;
          if (score_gt(work, high)) high <= work;
          state <= ACK;
        end
        ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Next-state of the paging/blink logic. Digits are registered from the
  // next-state values so page and digits always change on the same edge.
  always_comb begin
    page_nxt      = page;
    page_cnt_nxt  = page_cnt;
    blink_cnt_nxt = blink_cnt;
    blink_on_nxt  = blink_on;
    if (!game_over) begin
      page_nxt      = 1'b0;
      page_cnt_nxt  = '0;
      blink_cnt_nxt = '0;
      blink_on_nxt  = 1'b1;
    end else if (page_cnt == PAGE_LAST) begin
      page_cnt_nxt  = '0;
      page_nxt      = ~page;
      blink_cnt_nxt = '0;
      blink_on_nxt  = 1'b1;
    end else begin
      page_cnt_nxt = page_cnt + 1'b1;
      if (page) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt_nxt = '0;
          blink_on_nxt  = ~blink_on;
        end else begin
          blink_cnt_nxt = blink_cnt + 1'b1;
        end
      end
    end
    if (!page_nxt)         disp_nxt = score;
    else if (blink_on_nxt) disp_nxt = high;
    else                   disp_nxt = {4{BLANK_DIGIT}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      page      <= 1'b0;
      page_cnt  <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      disp      <= '0;
    end else begin
      page      <= page_nxt;
      page_cnt  <= page_cnt_nxt;
      blink_cnt <= blink_cnt_nxt;
      blink_on  <= blink_on_nxt;
      disp      <= disp_nxt;
    end
  end

  assign digit0 = disp[0];
  assign digit1 = disp[1];
  assign digit2 = disp[2];
  assign digit3 = disp[3];

endmodule

// File: tb/tb_score_display_scheduler.sv
// tb_score_display_scheduler
// Scoreboard bench: each add pushes the expected committed score (from an
// integer model of the score rules) into a queue; a monitor pops and
// compares whenever add_ack is seen.
module tb_score_display_scheduler;

  localparam int P = 16;
  localparam int B = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       add_req = 1'b0;
  logic [3:0] add_val = 4'd0;
  logic       clear_req = 1'b0;
  logic       game_over = 1'b0;
  logic       add_ack, page, busy;
  logic [3:0] digit0, digit1, digit2, digit3;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  int model_score = 0;
  int model_high = 0;

  always #5 clk = ~clk;

  score_display_scheduler #(.PAGE_CYCLES(P), .BLINK_CYCLES(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .add_req   (add_req),
    .add_val   (add_val),
    .add_ack   (add_ack),
    .clear_req (clear_req),
    .game_over (game_over),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .page      (page),
    .busy      (busy)
  );

  function automatic logic [15:0] to_digits(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  function automatic logic [15:0] shown();
    return {digit3, digit2, digit1, digit0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every ack must correspond to a queued add and show its score.
  always @(negedge clk) begin
    if (rst_n && add_ack) begin
      checkOutput("ack_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) checkOutput("ack_digits", 32'(shown()), 32'(exp_q.pop_front()));
    end
  end

  task automatic doReset();
    rst_n = 1'b0;
    add_req = 1'b0;
    clear_req = 1'b0;
    game_over = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_score = 0;
    model_high = 0;
    exp_q.delete();
    @(negedge clk);
  endtask

  // One add handshake. clr_same raises clear_req together with add_req;
  // clr_at>0 pulses clear_req so it is sampled at edge E+clr_at.
  task automatic applyStimulus(input logic [3:0] v, input bit clr_same, input int clr_at, input int exp_lat);
    int cyc = 0;
    int busy_cnt = 0;
    bit got = 0;
    int nv;
    nv = (v > 9) ? 9 : int'(v);
    if (clr_same) model_score = 0;
    model_score = model_score + nv;
    if (model_score > 9999) model_score = 9999;
    if (model_score > model_high) model_high = model_score;
    exp_q.push_back(to_digits(model_score));
    add_req = 1'b1;
    add_val = v;
    clear_req = clr_same;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      clear_req = 1'b0;
      if (clr_at != 0 && cyc == clr_at) clear_req = 1'b1;
      if (busy) busy_cnt++;
      if (add_ack) got = 1;
    end
    add_req = 1'b0;
    clear_req = 1'b0;
    checkOutput("ack_latency", 32'(cyc - 1), 32'(exp_lat));
    checkOutput("busy_cycles", 32'(busy_cnt), 32'd6);
    if (clr_at != 0) model_score = 0;
    @(negedge clk);
  endtask

  task automatic checkHigh();
    game_over = 1'b1;
    repeat (P) @(negedge clk);
    checkOutput("high_page", 32'(page), 32'd1);
    checkOutput("high_digits", 32'(shown()), 32'(to_digits(model_high)));
    game_over = 1'b0;
    @(negedge clk);
    checkOutput("page_return", 32'(page), 32'd0);
    checkOutput("score_return", 32'(shown()), 32'(to_digits(model_score)));
  endtask

  initial begin
    // Reset values
    doReset();
    checkOutput("rst_digits", 32'(shown()), 32'd0);
    checkOutput("rst_page", 32'(page), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ack", 32'(add_ack), 32'd0);

    // First add
    applyStimulus(4'd7, 0, 0, 6);
    checkHigh();

    // Ripple carry 0095 + 8 = 0103
    doReset();
    repeat (10) applyStimulus(4'd9, 0, 0, 6);
    applyStimulus(4'd5, 0, 0, 6);
    applyStimulus(4'd8, 0, 0, 6);
    checkHigh();

    // Saturation at 9999
    doReset();
    repeat (1110) applyStimulus(4'd9, 0, 0, 6);
    applyStimulus(4'd5, 0, 0, 6);
    applyStimulus(4'd9, 0, 0, 6);
    applyStimulus(4'd1, 0, 0, 6);
    checkHigh();

    // Clear during an add: commit 0045 first, then zero
    doReset();
    repeat (4) applyStimulus(4'd9, 0, 0, 6);
    applyStimulus(4'd4, 0, 0, 6);
    applyStimulus(4'd5, 0, 2, 6);
    @(negedge clk);
    checkOutput("clear_after_ack", 32'(shown()), 32'd0);
    checkHigh();

    // Same-cycle clear and add; clamp and zero add
    applyStimulus(4'd12, 1, 0, 7);
    applyStimulus(4'd3, 0, 0, 6);
    applyStimulus(4'd0, 0, 0, 6);
    checkOutput("zero_add", 32'(shown()), 32'(to_digits(12)));

    // Paging and blink with score 0012, high 0045
    checkOutput("pre_page_digits", 32'(shown()), 32'(to_digits(model_score)));
    game_over = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      bit exp_page, exp_on;
      logic [15:0] exp_d;
      @(negedge clk);
      exp_page = ((n / P) % 2) == 1;
      exp_on = (((n % P) / B) % 2) == 0;
      exp_d = !exp_page ? to_digits(model_score) : (exp_on ? to_digits(model_high) : 16'hFFFF);
      checkOutput("page_bit", 32'(page), 32'(exp_page));
      checkOutput("page_digits", 32'(shown()), 32'(exp_d));
    end
    game_over = 1'b0;
    @(negedge clk);
    checkOutput("go_drop_page", 32'(page), 32'd0);
    checkOutput("go_drop_digits", 32'(shown()), 32'(to_digits(model_score)));

    // Randomized adds and clears
    for (int i = 0; i < 60; i++) begin
      int r;
      logic [3:0] v;
      r = $urandom_range(0, 9);
      v = 4'($urandom_range(0, 15));
      if (r == 0) begin
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        model_score = 0;
        @(negedge clk);
        checkOutput("idle_clear", 32'(shown()), 32'd0);
      end else if (r == 1) begin
        applyStimulus(v, 0, $urandom_range(1, 5), 6);
      end else begin
        applyStimulus(v, 0, 0, 6);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    checkHigh();

    // Reset in the middle of an add aborts it with no ack
    applyStimulus(4'd6, 0, 0, 6);
    add_val = 4'd5;
    add_req = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    add_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_score = 0;
    model_high = 0;
    repeat (10) @(negedge clk);
    checkOutput("abort_digits", 32'(shown()), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkHigh();

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
